canny_window_feeder: RTL and testbench

Streaming 3x3 window generator that feeds the Canny non-maximum-suppression stage. Accepts one gradient-magnitude byte and one direction byte per cycle in raster order, buffers two image rows, and presents the three row windows (`cannyHoldOutA/B/C`) plus the middle-row direction window (`dirHoldOutB`) with a valid strobe. It is the transmitter side of the window interface that the suppression block consumes.

---
 rtl/canny_pkg.sv | 23 ++
 rtl/canny_line_buffer.sv | 26 ++
 rtl/canny_window_feeder.sv | 150 +++++++++++++++
 tb/tb_canny_window_feeder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny window feeder and its line buffers.
package canny_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_W = 3 * PIX_W;

    // Byte-lane LSBs inside a 24-bit window row: W/N high, C middle, E/S low
    localparam int LANE_W_LSB = 16;
    localparam int LANE_C_LSB = 8;
    localparam int LANE_E_LSB = 0;

    localparam logic [PIX_W-1:0] DIR_NW = 8'd255;
    localparam logic [PIX_W-1:0] DIR_N  = 8'd192;
    localparam logic [PIX_W-1:0] DIR_NE = 8'd128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/canny_line_buffer.sv
// Single-port row buffer: read data reflects the stored word at i_addr before
// this cycle's write lands, so the caller can read and overwrite in one cycle.
module canny_line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = 384,
    parameter int WIDTH = PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/canny_window_feeder.sv
// Raster-order 3x3 window generator for Canny non-maximum suppression.
// Define CANNY_DIR_WINDOW_EN to build the centre-row direction window.
module canny_window_feeder
    import canny_pkg::*;
#(
    parameter int IMGW = 384,
    parameter int IMGH = 384,
    parameter int CW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frameStart,
    input  logic              pixelValid,
    input  logic [PIX_W-1:0]  magIn,
    input  logic [PIX_W-1:0]  dirIn,
    output logic [WIN_W-1:0]  cannyHoldOutA,
    output logic [WIN_W-1:0]  cannyHoldOutB,
    output logic [WIN_W-1:0]  cannyHoldOutC,
    output logic [WIN_W-1:0]  dirHoldOutB,
    output logic              windowValid,
    output logic              frameDone
);

    localparam int AW = $clog2(IMGW);

    feeder_state_e r_state, w_state_nxt;
    logic [CW-1:0]    r_col, r_row;
    logic [WIN_W-1:0] r_winA, r_winB, r_winC;
    logic             r_win_valid, r_frame_done;
    logic [PIX_W-1:0] w_line0_rd, w_line1_rd;
    logic             w_accept, w_restart, w_last_col, w_last_row, w_interior;

    assign w_accept   = pixelValid && !frameStart &&
                        (r_state == ST_PRIME || r_state == ST_STREAM);
    assign w_restart  = frameStart && (r_state != ST_IDLE);
    assign w_last_col = (r_col == CW'(IMGW - 1));
    assign w_last_row = (r_row == CW'(IMGH - 1));
    assign w_interior = (r_row >= CW'(2)) && (r_col >= CW'(2));

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (frameStart) w_state_nxt = ST_PRIME;
            ST_PRIME: begin
                if (w_accept && w_last_row && w_last_col)
                    w_state_nxt = ST_DONE;
                else if (w_accept && r_row == CW'(2) && r_col == CW'(2))
                    w_state_nxt = ST_STREAM;
            end
            ST_STREAM: if (w_accept && w_last_row && w_last_col) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (frameStart)
            w_state_nxt = ST_PRIME;
    end

    always_ff @(posedge clk) begin
        if (reset || frameStart) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line1 holds the previous row, Line0 the row before it; Line0 is fed
    // from Line1's outgoing word so the two buffers act as a row delay chain.
    canny_line_buffer #(.DEPTH(IMGW), .WIDTH(PIX_W), .AW(AW)) u_line0 (
        .i_clk   (clk),
        .i_we    (w_accept),
        .i_addr  (r_col[AW-1:0]),
        .i_wdata (w_line1_rd),
        .o_rdata (w_line0_rd)
    );

    canny_line_buffer #(.DEPTH(IMGW), .WIDTH(PIX_W), .AW(AW)) u_line1 (
        .i_clk   (clk),
        .i_we    (w_accept),
        .i_addr  (r_col[AW-1:0]),
        .i_wdata (magIn),
        .o_rdata (w_line1_rd)
    );

    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_winA <= '0;
            r_winB <= '0;
            r_winC <= '0;
        end else if (w_accept) begin
            r_winA <= {r_winA[LANE_W_LSB-1:LANE_E_LSB], w_line0_rd};
            r_winB <= {r_winB[LANE_W_LSB-1:LANE_E_LSB], w_line1_rd};
            r_winC <= {r_winC[LANE_W_LSB-1:LANE_E_LSB], magIn};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || frameStart) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_accept && w_interior;
            r_frame_done <= w_accept && w_last_row && w_last_col;
        end
    end

`ifdef CANNY_DIR_WINDOW_EN
    logic [PIX_W-1:0] w_dir_rd;
    logic [WIN_W-1:0] r_dirB;

    canny_line_buffer #(.DEPTH(IMGW), .WIDTH(PIX_W), .AW(AW)) u_dir_line (
        .i_clk   (clk),
        .i_we    (w_accept),
        .i_addr  (r_col[AW-1:0]),
        .i_wdata (dirIn),
        .o_rdata (w_dir_rd)
    );

    always_ff @(posedge clk) begin
        if (reset || w_restart)
            r_dirB <= '0;
        else if (w_accept)
            r_dirB <= {r_dirB[LANE_W_LSB-1:LANE_E_LSB], w_dir_rd};
    end

    assign dirHoldOutB = r_dirB;
`else
    // dirIn is masked to zero so the port stays consumed without any logic
    assign dirHoldOutB = {3{dirIn & 8'h00}};
`endif

    assign cannyHoldOutA = r_winA;
    assign cannyHoldOutB = r_winB;
    assign cannyHoldOutC = r_winC;
    assign windowValid   = r_win_valid;
    assign frameDone     = r_frame_done;

endmodule

// File: tb/tb_canny_window_feeder.sv
// Directed bench for canny_window_feeder on an 8x4 ramp image.
module tb_canny_window_feeder;
    import canny_pkg::*;

    localparam int IMGW = 8;
    localparam int IMGH = 4;
    localparam int NPIX = IMGW * IMGH;

    logic        clk = 1'b0;
    logic        reset, frameStart, pixelValid;
    logic [7:0]  magIn, dirIn;
    logic [23:0] cannyHoldOutA, cannyHoldOutB, cannyHoldOutC, dirHoldOutB;
    logic        windowValid, frameDone;

    int n_cmp = 0;
    int n_err = 0;

    canny_window_feeder #(.IMGW(IMGW), .IMGH(IMGH), .CW(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .frameStart    (frameStart),
        .pixelValid    (pixelValid),
        .magIn         (magIn),
        .dirIn         (dirIn),
        .cannyHoldOutA (cannyHoldOutA),
        .cannyHoldOutB (cannyHoldOutB),
        .cannyHoldOutC (cannyHoldOutC),
        .dirHoldOutB   (dirHoldOutB),
        .windowValid   (windowValid),
        .frameDone     (frameDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ramp window row ending at (r,c): {p(c-2), p(c-1), p(c)}
    function automatic logic [23:0] win(input int base, input int r, input int c);
        int p;
        p = base + r * IMGW + c;
        return {8'(p - 2), 8'(p - 1), 8'(p)};
    endfunction

    function automatic logic [23:0] dir_win(input int centre_row);
`ifdef CANNY_DIR_WINDOW_EN
        return (centre_row == 1) ? 24'hC0C0C0 : 24'h808080;
`else
        return (centre_row >= 0) ? 24'h000000 : 24'h000000;
`endif
    endfunction

    task automatic run_frame(input int base, input int gap_at, input int gap_len, input int n_pix);
        int nwin;
        int r, c;
        logic [23:0] held_b;
        nwin   = 0;
        held_b = 24'h0;
        for (int i = 0; i < n_pix; i++) begin
            r = i / IMGW;
            c = i % IMGW;
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    pixelValid = 1'b0;
                    magIn      = 8'hEE;
                    step();
                    check("gap_valid", 32'(windowValid), 32'd0);
                    check("gap_holdB", 32'(cannyHoldOutB), 32'(held_b));
                end
            end
            pixelValid = 1'b1;
            magIn      = 8'(base + i);
            dirIn      = (r == 1) ? DIR_N : DIR_NE;
            step();
            if (r >= 2 && c >= 2) begin
                nwin++;
                held_b = win(base, r - 1, c);
                check("win_valid", 32'(windowValid), 32'd1);
                check("win_A", 32'(cannyHoldOutA), 32'(win(base, r - 2, c)));
                check("win_B", 32'(cannyHoldOutB), 32'(held_b));
                check("win_C", 32'(cannyHoldOutC), 32'(win(base, r, c)));
                check("win_dirB", 32'(dirHoldOutB), 32'(dir_win(r - 1)));
                if (r == 3 && c == 2)
                    check("row3_first_B", 32'(cannyHoldOutB), 32'(24'h101112 + 24'(base) * 24'h010101));
            end else begin
                check("edge_novalid", 32'(windowValid), 32'd0);
            end
            check("frameDone", 32'(frameDone), 32'(i == NPIX - 1));
        end
        pixelValid = 1'b0;
        if (n_pix == NPIX)
            check("win_count", 32'(nwin), 32'((IMGW - 2) * (IMGH - 2)));
    endtask

    task automatic pulse_start();
        frameStart = 1'b1;
        pixelValid = 1'b0;
        step();
        frameStart = 1'b0;
        check("start_novalid", 32'(windowValid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; frameStart = 1'b0; pixelValid = 1'b0; magIn = 8'h0; dirIn = 8'h0;
        for (int k = 0; k < 3; k++) begin
            frameStart = ~frameStart;
            pixelValid = ~pixelValid;
            magIn      = 8'h55;
            step();
        end
        check("rst_A", 32'(cannyHoldOutA), 32'd0);
        check("rst_B", 32'(cannyHoldOutB), 32'd0);
        check("rst_C", 32'(cannyHoldOutC), 32'd0);
        check("rst_dirB", 32'(dirHoldOutB), 32'd0);
        check("rst_valid", 32'(windowValid), 32'd0);
        check("rst_done", 32'(frameDone), 32'd0);

        // Pixels in IDLE must not be accepted
        reset = 1'b0; frameStart = 1'b0; pixelValid = 1'b1; magIn = 8'hAA;
        step();
        step();
        check("idle_novalid", 32'(windowValid), 32'd0);

        // Plain ramp frame
        pulse_start();
        run_frame(0, -1, 0, NPIX);
        step();
        check("post_done", 32'(frameDone), 32'd0);
        check("post_valid", 32'(windowValid), 32'd0);

        // Bubbles before row 2, col 3
        pulse_start();
        run_frame(0, 2 * IMGW + 3, 3, NPIX);
        step();

        // Restart at row 2, col 5 with a new pixel offset
        pulse_start();
        run_frame(8'h20, -1, 0, 2 * IMGW + 5);
        pulse_start();
        check("restart_clrA", 32'(cannyHoldOutA), 32'd0);
        run_frame(8'h40, -1, 0, NPIX);
        step();

        // Mid-frame reset
        pulse_start();
        run_frame(0, -1, 0, 2 * IMGW + 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", 32'(windowValid), 32'd0);
        check("midrst_A", 32'(cannyHoldOutA), 32'd0);
        check("midrst_C", 32'(cannyHoldOutC), 32'd0);
        pixelValid = 1'b1;
        magIn      = 8'h77;
        step();
        step();
        pixelValid = 1'b0;
        check("midrst_idle", 32'(windowValid), 32'd0);
        check("midrst_holdC", 32'(cannyHoldOutC), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
